imem_boot_loader: RTL and testbench

- Upstream of the RISC_V core and IMEM; fills instruction memory from a byte stream, then releases the core from reset.
- Stream format: 16-bit little-endian word count N, then N little-endian 32-bit instruction words.
- Each assembled word goes to IMEM through a single-cycle write strobe at word index 0..N-1.
- Holds core reset asserted (core_rst_n low) until the full image is written; a bad image holds it forever.

---
 rtl/imem_boot_loader_if.sv | 37 +++
 rtl/imem_boot_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// rtl/imem_boot_loader_if.sv - byte stream and IMEM write bus for the boot loader
//
// Purpose: bundles the incoming boot byte stream and the outgoing IMEM write
// port so the loader and its environment connect through one interface.
//
// Signals:
//   byte_valid  source has a byte on byte_data
//   byte_data   stream byte (8 bits)
//   byte_ready  loader accepts a byte this cycle
//   wr_en       one-cycle IMEM write strobe
//   wr_addr     IMEM word index (ADDR_WIDTH bits)
//   wr_data     assembled instruction word (DATA_WIDTH bits)
//
// Modports:
//   master  byte source / IMEM side (drives the stream, observes the writes)
//   slave   the loader itself
interface imem_boot_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - fills IMEM from a byte stream, then releases the core
//
// Purpose: parses a boot image (16-bit LE word count N, then N LE 32-bit
// words), writes each word to IMEM with a single-cycle strobe at index
// 0..N-1, and holds the core in reset until the whole image is written.
// An oversize image (N > MEM_SIZE) is rejected and holds the core in reset
// until rst_n.
//
// Optional feature: define IMEM_BOOT_LOADER_CHECKSUM_EN to require a trailing
// checksum byte (XOR of the length bytes and all data bytes) before DONE.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         imem_boot_loader_if.slave (byte stream in, IMEM write out)
//   core_rst_n  active-low reset to the core; rises only on entry to DONE
//   busy        load in progress
//   done        image loaded, core running
//   err         image rejected (sticky until rst_n)
module imem_boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_SIZE   = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  imem_boot_loader_if.slave    bus,
  output logic                 core_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  // State entered once the last word (or an empty image) has been handled.
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CSUM;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  localparam logic [15:0] MAX_LEN = 16'(MEM_SIZE);

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [15:0]           len_q;
  logic [15:0]           word_idx_q;
  logic [1:0]            byte_cnt_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic                  accept;
  logic [15:0]           len_in;
  logic                  last_word;
  logic [DATA_WIDTH-1:0] word_next;

  assign accept    = bus.byte_valid && ready_q;
  assign len_in    = {bus.byte_data, len_q[7:0]};
  assign last_word = (word_idx_q + 16'd1) == len_q;
  // Bytes shift in from the top so the first byte ends up in [7:0].
  assign word_next = {bus.byte_data, word_q[DATA_WIDTH-1:8]};

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LEN0:  if (accept) state_d = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if (len_in > MAX_LEN)    state_d = S_ERR;
          else if (len_in == 16'd0) state_d = S_FINAL;
          else                      state_d = S_DATA;
        end
      end
      S_DATA:  if (accept && byte_cnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = last_word ? S_FINAL : S_DATA;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      S_CSUM:  if (accept) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
`endif
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // byte_ready is registered from the next state so it is 0 throughout
  // reset and comes up one cycle after rst_n releases.
  always_comb begin
    ready_d = 1'b0;
    case (state_d)
      S_LEN0, S_LEN1, S_DATA: ready_d = 1'b1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      S_CSUM:                 ready_d = 1'b1;
`endif
      default:                ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LEN0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  // Datapath: length capture, word assembly and write staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
    end else begin
      if (accept) begin
        case (state_q)
          S_LEN0: len_q[7:0]  <= bus.byte_data;
          S_LEN1: len_q[15:8] <= bus.byte_data;
          S_DATA: begin
            word_q     <= word_next;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              wr_data_q <= word_next;
              wr_addr_q <= word_idx_q[ADDR_WIDTH-1:0];
            end
          end
          default: ;
        endcase
      end
      // N <= MEM_SIZE bounds the index, so this never wraps.
      if (state_q == S_WRITE) word_idx_q <= word_idx_q + 16'd1;
    end
  end

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  // Running XOR of every byte before the checksum byte itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (accept && state_q != S_CSUM) begin
      csum_q <= csum_q ^ bus.byte_data;
    end
  end
`endif

  assign bus.byte_ready = ready_q;
  assign bus.wr_en      = (state_q == S_WRITE);
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;

  assign core_rst_n = (state_q == S_DONE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERR);

  always_comb begin
    busy = 1'b0;
    case (state_q)
      S_LEN1, S_DATA, S_WRITE: busy = 1'b1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      S_CSUM:                  busy = 1'b1;
`endif
      default:                 busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard testbench for imem_boot_loader
module tb_imem_boot_loader;
  localparam int MEM_SIZE = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_rst_n, busy, done, err;

  always #5 clk = ~clk;

  imem_boot_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  imem_boot_loader #(
    .DATA_WIDTH(32),
    .MEM_SIZE  (MEM_SIZE),
    .ADDR_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .core_rst_n(core_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  stim[$];
  logic [31:0] img_words[$];
  int  wr_count = 0;
  time last_wr_t = 0;
  time last_acc_t = 0;
  time done_t = 0;
  bit  done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every write strobe is matched against the scoreboard queue.
  always @(negedge clk) begin : monitor
    logic [39:0] e;
    if (rst_n && bus.wr_en) begin
      wr_count++;
      last_wr_t = $time;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, want no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.wr_addr), 64'(e[39:32]));
        check("wr_data", 64'(bus.wr_data), 64'(e[31:0]));
      end
    end
    if (done && !done_seen) begin
      done_seen = 1;
      done_t = $time;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    wr_count = 0;
    done_seen = 0;
    @(negedge clk);
  endtask

  // mode 0: valid always high, 1: toggles every cycle, 2: random gaps.
  task automatic send(input int mode, output bit timeout);
    int idx = 0;
    int cyc = 0;
    bit go, will;
    while (idx < stim.size() && cyc < 8000) begin
      @(negedge clk);
      if (mode == 0)      go = 1'b1;
      else if (mode == 1) go = (cyc % 2 == 0);
      else                go = ($urandom_range(3) != 0);
      bus.byte_valid = go;
      bus.byte_data  = go ? stim[idx] : 8'($urandom);
      will = go && bus.byte_ready;
      @(posedge clk);
      if (will) begin
        idx++;
        last_acc_t = $time;
      end
      cyc++;
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    timeout = (idx < stim.size());
  endtask

  task automatic finish_image(input bit exp_done, input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_done"},       64'(done),         64'(exp_done));
    check({tag, "_err"},        64'(err),          64'(!exp_done));
    check({tag, "_core_rst_n"}, 64'(core_rst_n),   64'(exp_done));
    check({tag, "_busy"},       64'(busy),         64'(0));
    check({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'(0));
    check({tag, "_both"},       64'(done && err),  64'(0));
    check({tag, "_pending"},    64'(exp_q.size()), 64'(0));
  endtask

  // Reference model: serialises img_words as the boot image and predicts
  // the writes and the terminal outcome from the image rules alone.
  task automatic load_image(input int n, input int mode, input bit corrupt, input string tag);
    bit to, ok;
    logic [7:0] x;
    longint w;
    stim.delete();
    stim.push_back(8'(n % 256));
    stim.push_back(8'(n / 256));
    ok = (n <= MEM_SIZE);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        w = longint'(img_words[i]);
        for (int k = 0; k < 4; k++) stim.push_back(8'((w >> (8 * k)) % 256));
        exp_q.push_back({8'(i), img_words[i]});
      end
    end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    if (ok) begin
      x = 8'h00;
      foreach (stim[j]) x = x ^ stim[j];
      stim.push_back(corrupt ? (x ^ 8'h01) : x);
      ok = !corrupt;
    end
`else
    x = 8'(corrupt);
`endif
    send(mode, to);
    check({tag, "_timeout"}, 64'(to), 64'(0));
    finish_image(ok, tag);
  endtask

  initial begin
    bit to;
    int n;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_byte_ready", 64'(bus.byte_ready), 0);
    check("rst_wr_en",      64'(bus.wr_en),      0);
    check("rst_wr_addr",    64'(bus.wr_addr),    0);
    check("rst_wr_data",    64'(bus.wr_data),    0);
    check("rst_core_rst_n", 64'(core_rst_n),     0);
    check("rst_busy",       64'(busy),           0);
    check("rst_done",       64'(done),           0);
    check("rst_err",        64'(err),            0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word image, valid always high.
    img_words.delete();
    img_words.push_back(32'h00A00513);
    img_words.push_back(32'h00100293);
    load_image(2, 0, 0, "t1");
    check("t1_wr_count", 64'(wr_count), 2);
`ifndef IMEM_BOOT_LOADER_CHECKSUM_EN
    check("t1_wr_latency", 64'(last_wr_t - last_acc_t), 5);
    check("t1_done_time",  64'(done_t - last_wr_t), 10);
`else
    check("t1_done_time",  64'(done_t - last_acc_t), 5);
`endif

    // Empty image.
    do_reset();
    img_words.delete();
    load_image(0, 0, 0, "t2");
    check("t2_wr_count", 64'(wr_count), 0);
    check("t2_done_time", 64'(done_t - last_acc_t), 5);

    // Oversize image N = 257: rejected, sticky until reset.
    do_reset();
    load_image(257, 0, 0, "t3");
    repeat (20) @(negedge clk);
    check("t3_err_sticky", 64'(err), 1);
    check("t3_core_held",  64'(core_rst_n), 0);
    check("t3_wr_count",   64'(wr_count), 0);
    do_reset();
    check("t3_err_cleared", 64'(err), 0);

    // Single word with byte_valid toggling.
    img_words.delete();
    img_words.push_back($urandom);
    load_image(1, 1, 0, "t4");
    check("t4_wr_count", 64'(wr_count), 1);

    // Reset in the middle of a word.
    do_reset();
    stim.delete();
    stim.push_back(8'h01); stim.push_back(8'h00);
    stim.push_back(8'hEF); stim.push_back(8'hBE);
    send(0, to);
    check("t5_partial_timeout", 64'(to), 0);
    check("t5_busy_midload", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t5_byte_ready", 64'(bus.byte_ready), 0);
    check("t5_wr_en",      64'(bus.wr_en),      0);
    check("t5_wr_addr",    64'(bus.wr_addr),    0);
    check("t5_wr_data",    64'(bus.wr_data),    0);
    check("t5_core_rst_n", 64'(core_rst_n),     0);
    check("t5_busy",       64'(busy),           0);
    check("t5_done",       64'(done),           0);
    check("t5_err",        64'(err),            0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    wr_count = 0;
    done_seen = 0;
    @(negedge clk);
    img_words.delete();
    img_words.push_back(32'hDEADBEEF);
    load_image(1, 0, 0, "t5");
    check("t5_wr_count", 64'(wr_count), 1);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    // Checksum match and mismatch.
    do_reset();
    img_words.delete();
    img_words.push_back(32'h44332211);
    load_image(1, 0, 0, "t6_good");
    do_reset();
    load_image(1, 0, 1, "t6_bad");
    check("t6_bad_wr_count", 64'(wr_count), 1);
`endif

    // Randomized images, including the N = MEM_SIZE boundary and oversize N.
    for (int r = 0; r < 10; r++) begin
      do_reset();
      if (r == 0)      n = MEM_SIZE;
      else if (r == 1) n = MEM_SIZE + 1;
      else if (r == 2) n = $urandom_range(65535, MEM_SIZE + 2);
      else             n = $urandom_range(8, 1);
      img_words.delete();
      if (n <= MEM_SIZE)
        for (int i = 0; i < n; i++) img_words.push_back($urandom);
      load_image(n, (r % 3 == 0) ? 0 : 2, 0, $sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_wr_count", r), 64'(wr_count),
            64'((n <= MEM_SIZE) ? n : 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
